// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Pure definitions: no latency, no flow control.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_MD_WAIT = 2'd1,
        HZ_MD_DONE = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic             we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage register ids in, stall/flush/forward controls out.
// Wires only: no latency, no backpressure.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             ex_md_req;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             md_done;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             flush_ex;
    logic             md_start;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_redirect, ex_md_req,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write, md_done,
        input  stall_if, stall_id, stall_ex, flush_id, flush_ex, md_start,
        input  fwd_a, fwd_b, md_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_redirect, ex_md_req,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, md_done,
        output stall_if, stall_id, stall_ex, flush_id, flush_ex, md_start,
        output fwd_a, fwd_b, md_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// EX operand bypass select for one source register; MEM result beats WB result.
// Latency: combinational. Backpressure: none.
module forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_we,
    output fwd_sel_e          o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (fwd_hit(i_mem_we, i_mem_rd, i_rs)) begin
            o_sel = FWD_MEM;
        end else if (fwd_hit(i_wb_we, i_wb_rd, i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencing, MDU handoff FSM with timeout, forwarding selects, perf counters.
// Latency: controls are combinational on state+inputs; backpressure is the stall outputs themselves.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rstn,
    hazard_ctrl_if.slave hz
);

    localparam int                WC_W    = $clog2(MD_TIMEOUT);
    localparam logic [WC_W-1:0]   WC_LAST = WC_W'(MD_TIMEOUT - 2);

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    logic [WC_W-1:0]  r_wcnt;
    logic [WC_W-1:0]  w_wcnt_nxt;
    logic             r_md_err;
    logic             w_err_set;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_load_use;
    logic             w_stall_if;
    logic             w_stall_id;
    logic             w_stall_ex;
    logic             w_flush_id;
    logic             w_flush_ex;
    logic             w_md_start;
    fwd_sel_e         w_fwd_a;
    fwd_sel_e         w_fwd_b;

    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                        ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_err_set   = 1'b0;
        w_flush_evt = 1'b0;
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_stall_ex  = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        w_md_start  = 1'b0;
        if (rstn) begin
            case (r_state)
                // MD_DONE still holds the MDU instruction in EX, so its md_req is not a new op.
                HZ_RUN, HZ_MD_DONE: begin
                    w_state_nxt = HZ_RUN;
                    if (hz.ex_redirect) begin
                        w_flush_id  = 1'b1;
                        w_flush_ex  = 1'b1;
                        w_flush_evt = 1'b1;
                    end else if (hz.ex_md_req && (r_state == HZ_RUN)) begin
                        w_md_start  = 1'b1;
                        w_stall_if  = 1'b1;
                        w_stall_id  = 1'b1;
                        w_stall_ex  = 1'b1;
                        w_state_nxt = HZ_MD_WAIT;
                        w_wcnt_nxt  = '0;
                    end else if (w_load_use) begin
                        w_stall_if = 1'b1;
                        w_stall_id = 1'b1;
                        w_flush_ex = 1'b1;
                    end
                end
                HZ_MD_WAIT: begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_stall_ex = 1'b1;
                    if (hz.md_done) begin
                        w_state_nxt = HZ_MD_DONE;
                    end else begin
                        w_wcnt_nxt = r_wcnt + 1'b1;
                        if (r_wcnt == WC_LAST) begin
                            w_err_set   = 1'b1;
                            w_state_nxt = HZ_MD_DONE;
                        end
                    end
                end
                default: w_state_nxt = HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= HZ_RUN;
            r_wcnt      <= '0;
            r_md_err    <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_err_set) begin
                r_md_err <= 1'b1;
            end
            if (w_stall_if && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    forward_unit u_fwd_a (
        .i_rs     (hz.ex_rs1),
        .i_mem_rd (hz.mem_rd),
        .i_mem_we (hz.mem_reg_write),
        .i_wb_rd  (hz.wb_rd),
        .i_wb_we  (hz.wb_reg_write),
        .o_sel    (w_fwd_a)
    );

    forward_unit u_fwd_b (
        .i_rs     (hz.ex_rs2),
        .i_mem_rd (hz.mem_rd),
        .i_mem_we (hz.mem_reg_write),
        .i_wb_rd  (hz.wb_rd),
        .i_wb_we  (hz.wb_reg_write),
        .o_sel    (w_fwd_b)
    );

    assign hz.stall_if  = w_stall_if;
    assign hz.stall_id  = w_stall_id;
    assign hz.stall_ex  = w_stall_ex;
    assign hz.flush_id  = w_flush_id;
    assign hz.flush_ex  = w_flush_ex;
    assign hz.md_start  = w_md_start;
    assign hz.fwd_a     = w_fwd_a;
    assign hz.fwd_b     = w_fwd_b;
    assign hz.md_err    = r_md_err;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;

    // A single EX instruction is either a taken branch or an MDU op, never both.
    a_one_ex_op: assert property (@(posedge clk) disable iff (!rstn)
                                  !(hz.ex_redirect && hz.ex_md_req));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table for single-cycle responses, hand sequences for MDU/timeout/reset/saturation.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int TO = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hif();

    hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hif)
    );

    typedef struct packed {
        logic       stall_if;
        logic       stall_id;
        logic       stall_ex;
        logic       flush_id;
        logic       flush_ex;
        logic       md_start;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
    } out_t;

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       use1, use2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       mem_read, redir;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        out_t       exp;
    } vec_t;

    vec_t vt[$];
    out_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic out_t mko(input logic si, sid, sex, fid, fex, ms,
                                 input logic [1:0] fa, fb);
        out_t o;
        o.stall_if = si;  o.stall_id = sid; o.stall_ex = sex;
        o.flush_id = fid; o.flush_ex = fex; o.md_start = ms;
        o.fwd_a    = fa;  o.fwd_b    = fb;
        return o;
    endfunction

    function automatic vec_t mkv(input logic [4:0] r1, r2, input logic u1, u2,
                                 input logic [4:0] e1, e2, erd, input logic mr, rd_,
                                 input logic [4:0] mrd, input logic mw,
                                 input logic [4:0] wrd, input logic ww, input out_t e);
        vec_t v;
        v.id_rs1 = r1;  v.id_rs2 = r2;  v.use1 = u1;  v.use2 = u2;
        v.ex_rs1 = e1;  v.ex_rs2 = e2;  v.ex_rd = erd;
        v.mem_read = mr; v.redir = rd_;
        v.mem_rd = mrd; v.mem_we = mw;  v.wb_rd = wrd; v.wb_we = ww;
        v.exp = e;
        return v;
    endfunction

    function automatic out_t cur_out();
        return mko(hif.stall_if, hif.stall_id, hif.stall_ex, hif.flush_id,
                   hif.flush_ex, hif.md_start, hif.fwd_a, hif.fwd_b);
    endfunction

    task automatic idle();
        hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
        hif.ex_rs1 = '0; hif.ex_rs2 = '0; hif.ex_rd = '0;
        hif.ex_mem_read = 1'b0; hif.ex_redirect = 1'b0; hif.ex_md_req = 1'b0;
        hif.mem_rd = '0; hif.mem_reg_write = 1'b0; hif.wb_rd = '0; hif.wb_reg_write = 1'b0;
        hif.md_done = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        idle();
        hif.id_rs1 = v.id_rs1; hif.id_rs2 = v.id_rs2;
        hif.id_use_rs1 = v.use1; hif.id_use_rs2 = v.use2;
        hif.ex_rs1 = v.ex_rs1; hif.ex_rs2 = v.ex_rs2; hif.ex_rd = v.ex_rd;
        hif.ex_mem_read = v.mem_read; hif.ex_redirect = v.redir;
        hif.mem_rd = v.mem_rd; hif.mem_reg_write = v.mem_we;
        hif.wb_rd = v.wb_rd; hif.wb_reg_write = v.wb_we;
    endtask

    task automatic load_use();
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
    endtask

    // Called at posedge+1 with inputs already driven: push expectation, compare at negedge, advance.
    task automatic expect_cyc(input string nm, input out_t e);
        out_t a, x;
        sb.push_back(e);
        @(negedge clk);
        a = cur_out();
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            x = sb.pop_front();
            chk(nm, a, x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    localparam out_t O_NONE  = '0;
    localparam out_t O_LU    = 10'b11_0010_0000;
    localparam out_t O_FL    = 10'b00_0110_0000;
    localparam out_t O_START = 10'b11_1001_0000;
    localparam out_t O_WAIT  = 10'b11_1000_0000;

    initial begin
        idle();
        rstn = 1'b0;
        // Requests present while in reset must not leak to the outputs.
        hif.ex_md_req = 1'b1;
        load_use();
        #7;
        chk("rst_outputs", {hif.stall_if, hif.stall_id, hif.stall_ex, hif.flush_id, hif.flush_ex, hif.md_start}, 6'b0);
        chk("rst_stall_cnt", 32'(hif.stall_cnt), 0);
        chk("rst_flush_cnt", 32'(hif.flush_cnt), 0);
        chk("rst_md_err", 32'(hif.md_err), 0);
        idle();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        vt.push_back(mkv(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, O_NONE));
        vt.push_back(mkv(5,0,1,0, 0,0,5, 1,0, 0,0,0,0, O_LU));
        vt.push_back(mkv(0,0,1,0, 0,0,0, 1,0, 0,0,0,0, O_NONE));
        vt.push_back(mkv(1,7,1,1, 0,0,7, 1,0, 0,0,0,0, O_LU));
        vt.push_back(mkv(1,7,1,0, 0,0,7, 1,0, 0,0,0,0, O_NONE));
        vt.push_back(mkv(5,0,1,0, 0,0,5, 0,0, 0,0,0,0, O_NONE));
        vt.push_back(mkv(5,0,1,0, 0,0,5, 1,1, 0,0,0,0, O_FL));
        vt.push_back(mkv(0,0,0,0, 3,0,0, 0,0, 3,1,3,1, mko(0,0,0,0,0,0,2'b10,2'b00)));
        vt.push_back(mkv(0,0,0,0, 3,0,0, 0,0, 3,0,3,1, mko(0,0,0,0,0,0,2'b01,2'b00)));
        vt.push_back(mkv(0,0,0,0, 0,0,0, 0,0, 0,1,0,1, O_NONE));
        vt.push_back(mkv(0,0,0,0, 4,9,0, 0,0, 4,1,9,1, mko(0,0,0,0,0,0,2'b10,2'b01)));
        vt.push_back(mkv(0,0,0,0, 9,9,0, 0,0, 9,0,9,0, O_NONE));
        vt.push_back(mkv(0,0,0,0, 0,0,0, 0,1, 0,0,0,0, O_FL));
        vt.push_back(mkv(0,0,0,0, 6,6,0, 0,0, 6,1,6,1, mko(0,0,0,0,0,0,2'b10,2'b10)));

        for (int i = 0; i < vt.size(); i++) begin
            drive_vec(vt[i]);
            expect_cyc($sformatf("vec%0d", i), vt[i].exp);
        end
        idle();
        chk("tbl_stall_cnt", 32'(hif.stall_cnt), 2);
        chk("tbl_flush_cnt", 32'(hif.flush_cnt), 2);

        // MDU op with md_done on the 5th wait cycle; load-use during the wait is ignored.
        do_reset();
        hif.ex_md_req = 1'b1;
        expect_cyc("md_start", O_START);
        for (int k = 1; k <= 5; k++) begin
            hif.md_done = (k == 5);
            load_use();
            expect_cyc($sformatf("md_wait%0d", k), O_WAIT);
        end
        idle();
        hif.ex_md_req = 1'b1;
        expect_cyc("md_done_state", O_NONE);
        idle();
        expect_cyc("md_back_run", O_NONE);
        chk("md_stall_cnt", 32'(hif.stall_cnt), 6);
        chk("md_err_clear", 32'(hif.md_err), 0);

        // Fastest op: done in first wait cycle, then a redirect in MD_DONE.
        hif.ex_md_req = 1'b1;
        expect_cyc("fast_start", O_START);
        hif.md_done = 1'b1;
        expect_cyc("fast_wait", O_WAIT);
        idle();
        hif.ex_redirect = 1'b1;
        expect_cyc("fast_done_redir", O_FL);
        idle();
        hif.md_done = 1'b1;
        expect_cyc("run_md_done_ignored", O_NONE);
        idle();
        expect_cyc("run_after_stray_done", O_NONE);
        chk("fast_stall_cnt", 32'(hif.stall_cnt), 8);
        chk("fast_flush_cnt", 32'(hif.flush_cnt), 1);

        // Timeout: no md_done, forced release after TO-1 wait cycles.
        do_reset();
        hif.ex_md_req = 1'b1;
        expect_cyc("to_start", O_START);
        for (int k = 1; k <= TO - 1; k++) begin
            expect_cyc($sformatf("to_wait%0d", k), O_WAIT);
            chk($sformatf("to_err%0d", k), 32'(hif.md_err), (k == TO - 1) ? 1 : 0);
        end
        expect_cyc("to_done_state", O_NONE);
        hif.ex_md_req = 1'b0;
        expect_cyc("to_back_run", O_NONE);
        chk("to_err_sticky", 32'(hif.md_err), 1);
        chk("to_stall_cnt", 32'(hif.stall_cnt), TO);

        // Async reset mid-wait, off the clock edge.
        hif.ex_md_req = 1'b1;
        expect_cyc("ar_start", O_START);
        expect_cyc("ar_wait", O_WAIT);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_outputs", {hif.stall_if, hif.stall_id, hif.stall_ex, hif.flush_id, hif.flush_ex, hif.md_start}, 6'b0);
        chk("ar_stall_cnt", 32'(hif.stall_cnt), 0);
        chk("ar_flush_cnt", 32'(hif.flush_cnt), 0);
        chk("ar_md_err", 32'(hif.md_err), 0);
        @(posedge clk);
        #1;
        idle();
        rstn = 1'b1;
        expect_cyc("ar_post_idle", O_NONE);
        hif.ex_md_req = 1'b1;
        expect_cyc("ar_fresh_start", O_START);
        hif.md_done = 1'b1;
        expect_cyc("ar_fresh_wait", O_WAIT);
        idle();
        expect_cyc("ar_fresh_done", O_NONE);

        // Counter saturation at all-ones.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            idle();
            load_use();
            expect_cyc($sformatf("sat_lu%0d", k), O_LU);
        end
        chk("sat_stall_cnt", 32'(hif.stall_cnt), (1 << CW) - 1);
        chk("sat_flush_zero", 32'(hif.flush_cnt), 0);
        for (int k = 0; k < 20; k++) begin
            idle();
            hif.ex_redirect = 1'b1;
            expect_cyc($sformatf("sat_fl%0d", k), O_FL);
        end
        idle();
        chk("sat_flush_cnt", 32'(hif.flush_cnt), (1 << CW) - 1);
        chk("sat_stall_hold", 32'(hif.stall_cnt), (1 << CW) - 1);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
